// File: rtl/fmt_pkt_sink.sv
// fmt_pkt_sink: grants the MCDF formatter, captures framed packets into a word FIFO, checks
// framing against the declared length and replays words on a FWFT valid/ready stream.
// Optional WAIT/RECV watchdog enabled by defining FMT_SINK_TIMEOUT_EN.
module fmt_pkt_sink #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        fmt_req_i,
    output logic        fmt_grant_o,
    input  logic [1:0]  fmt_chid_i,
    input  logic [5:0]  fmt_length_i,
    input  logic [31:0] fmt_data_i,
    input  logic        fmt_start_i,
    input  logic        fmt_end_i,
    output logic [31:0] pkt_data_o,
    output logic        pkt_vld_o,
    input  logic        pkt_rdy_i,
    output logic        pkt_sop_o,
    output logic        pkt_eop_o,
    output logic [1:0]  pkt_chid_o,
    output logic        len_err_o,
    output logic [15:0] pkt_cnt_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RECV = 2'd2} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state_reg, state_next;
    logic          grant_reg, grant_next;
    logic [5:0]    len_reg, len_next;
    logic [1:0]    chid_reg, chid_next;
    logic [6:0]    cnt_reg, cnt_next;
    logic          err_reg, err_next;
    logic [15:0]   pkt_cnt_reg, pkt_cnt_next;
`ifdef FMT_SINK_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'd14;
    logic [3:0]    timer_reg, timer_next;
`endif

    // FIFO entry layout: {data[31:0], sop, eop, chid[1:0]}
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   occ_reg, occ_after_pop, free_words, mem_cnt, req_len;
    logic          head_vld_reg;
    logic [35:0]   head_reg;
    logic          pop, push, want_push, push_sop, push_eop, full;
    logic          mem_empty, head_load, bypass, beat;
    logic [35:0]   push_entry;
    logic [6:0]    beat_base, beat_inc, len_ext;

    assign pop           = head_vld_reg & pkt_rdy_i;
    assign occ_after_pop = occ_reg - (AW+1)'(pop);
    assign free_words    = DEPTH_W - occ_after_pop;
    assign full          = (occ_after_pop == DEPTH_W);
    assign req_len       = {{(AW-5){1'b0}}, fmt_length_i};
    assign len_ext       = {1'b0, len_reg};
    assign beat_base     = (state_reg == WAIT) ? 7'd0 : cnt_reg;
    assign beat_inc      = beat_base + 7'd1;
    assign push          = want_push & ~full;
    assign push_entry    = {fmt_data_i, push_sop, push_eop, chid_reg};

    always_comb begin
        state_next   = state_reg;
        grant_next   = 1'b0;
        len_next     = len_reg;
        chid_next    = chid_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        pkt_cnt_next = pkt_cnt_reg;
        beat         = 1'b0;
        want_push    = 1'b0;
        push_sop     = 1'b0;
        push_eop     = 1'b0;
`ifdef FMT_SINK_TIMEOUT_EN
        timer_next   = timer_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (fmt_req_i && free_words >= req_len) begin
                    len_next   = fmt_length_i;
                    chid_next  = fmt_chid_i;
                    cnt_next   = 7'd0;
                    grant_next = 1'b1;
                    state_next = WAIT;
`ifdef FMT_SINK_TIMEOUT_EN
                    timer_next = 4'd0;
`endif
                end
            end
            WAIT: begin
                if (fmt_start_i) begin
                    beat     = 1'b1;
                    push_sop = 1'b1;
                end
`ifdef FMT_SINK_TIMEOUT_EN
                else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    timer_next = timer_reg + 4'd1;
                end
`endif
            end
            RECV: begin
                beat = 1'b1;
                if (fmt_start_i) err_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (beat) begin
            // The word that fills the declared length carries eop immediately, so an
            // over-long packet is already closed downstream even if that word drains early.
            if (beat_base < len_ext) begin
                want_push = 1'b1;
                push_eop  = fmt_end_i | (beat_inc == len_ext);
                cnt_next  = beat_inc;
                if (fmt_end_i && beat_inc != len_ext) err_next = 1'b1;
            end else begin
                err_next = 1'b1;
            end
            if (fmt_end_i) begin
                state_next   = IDLE;
                pkt_cnt_next = pkt_cnt_reg + 16'd1;
            end else begin
                state_next = RECV;
            end
`ifdef FMT_SINK_TIMEOUT_EN
            timer_next = 4'd0;
            if (state_reg == RECV && !fmt_end_i && cnt_reg == len_ext) begin
                if (timer_reg == TIMEOUT_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + 4'd1;
                end
            end
`endif
        end

        if (want_push && full) err_next = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg   <= IDLE;
            grant_reg   <= 1'b0;
            len_reg     <= 6'd0;
            chid_reg    <= 2'd0;
            cnt_reg     <= 7'd0;
            err_reg     <= 1'b0;
            pkt_cnt_reg <= 16'd0;
`ifdef FMT_SINK_TIMEOUT_EN
            timer_reg   <= 4'd0;
`endif
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            len_reg     <= len_next;
            chid_reg    <= chid_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            pkt_cnt_reg <= pkt_cnt_next;
`ifdef FMT_SINK_TIMEOUT_EN
            timer_reg   <= timer_next;
`endif
        end
    end

    // Head register holds the oldest word; an empty FIFO bypasses the array for 1-cycle latency.
    assign mem_cnt   = occ_reg - (AW+1)'(head_vld_reg);
    assign mem_empty = (mem_cnt == '0);
    assign head_load = ~head_vld_reg | pop;
    assign bypass    = push & mem_empty & head_load;

    always_ff @(posedge clk_i) begin
        if (push && !bypass) mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            head_vld_reg <= 1'b0;
            head_reg     <= '0;
        end else begin
            occ_reg <= occ_reg + (AW+1)'(push) - (AW+1)'(pop);
            if (push && !bypass) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (head_load) begin
                if (!mem_empty) begin
                    head_reg     <= mem[rd_ptr_reg];
                    rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
                    head_vld_reg <= 1'b1;
                end else if (push) begin
                    head_reg     <= push_entry;
                    head_vld_reg <= 1'b1;
                end else begin
                    head_vld_reg <= 1'b0;
                end
            end
        end
    end

    assign fmt_grant_o = grant_reg;
    assign pkt_data_o  = head_reg[35:4];
    assign pkt_sop_o   = head_reg[3];
    assign pkt_eop_o   = head_reg[2];
    assign pkt_chid_o  = head_reg[1:0];
    assign pkt_vld_o   = head_vld_reg;
    assign len_err_o   = err_reg;
    assign pkt_cnt_o   = pkt_cnt_reg;
endmodule

// File: tb/tb_fmt_pkt_sink.sv
// Bench for fmt_pkt_sink: table-driven packets, randomized traffic against a packet-level
// queue model, back-pressure grant throttling, mid-packet reset and optional timeout.
module tb_fmt_pkt_sink;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        fmt_req_i;
    logic        fmt_grant_o;
    logic [1:0]  fmt_chid_i;
    logic [5:0]  fmt_length_i;
    logic [31:0] fmt_data_i;
    logic        fmt_start_i;
    logic        fmt_end_i;
    logic [31:0] pkt_data_o;
    logic        pkt_vld_o;
    logic        pkt_rdy_i;
    logic        pkt_sop_o;
    logic        pkt_eop_o;
    logic [1:0]  pkt_chid_o;
    logic        len_err_o;
    logic [15:0] pkt_cnt_o;

    fmt_pkt_sink #(.DEPTH(64), .AW(6)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .fmt_req_i(fmt_req_i), .fmt_grant_o(fmt_grant_o),
        .fmt_chid_i(fmt_chid_i), .fmt_length_i(fmt_length_i), .fmt_data_i(fmt_data_i),
        .fmt_start_i(fmt_start_i), .fmt_end_i(fmt_end_i),
        .pkt_data_o(pkt_data_o), .pkt_vld_o(pkt_vld_o), .pkt_rdy_i(pkt_rdy_i),
        .pkt_sop_o(pkt_sop_o), .pkt_eop_o(pkt_eop_o), .pkt_chid_o(pkt_chid_o),
        .len_err_o(len_err_o), .pkt_cnt_o(pkt_cnt_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  chid;
    } word_t;

    typedef struct {
        logic [1:0] chid;
        int         decl;
        int         act;
        int         exp_words;
        logic       exp_err;
    } vec_t;

    word_t exp_q[$];
    word_t mon_got, mon_exp;
    vec_t  tbl[6];
    int    checks = 0;
    int    errors = 0;
    int    pops = 0;
    int    rdy_mode = 0;   // 0: stall, 1: always ready, 2: random
    int    exp_pkt_cnt = 0;
    logic  exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Packet-level model: the first min(declared, actual) words survive, framed sop..eop.
    task automatic expect_pkt(input logic [1:0] chid, input int decl, input int act,
                              input logic [31:0] base);
        int stored;
        word_t w;
        stored = (decl < act) ? decl : act;
        for (int i = 0; i < stored; i++) begin
            w.data = base + 32'(i);
            w.sop  = (i == 0);
            w.eop  = (i == stored - 1);
            w.chid = chid;
            exp_q.push_back(w);
        end
        exp_pkt_cnt++;
        if (decl != act) exp_err = 1'b1;
    endtask

    task automatic wait_grant(output logic got);
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (fmt_grant_o) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: got no grant, required a grant within 400 cycles");
        end
    endtask

    task automatic send_beats(input int act, input logic [31:0] base);
        for (int i = 0; i < act; i++) begin
            fmt_start_i = (i == 0);
            fmt_end_i   = (i == act - 1);
            fmt_data_i  = base + 32'(i);
            tick();
            if (i == 0) check("grant_pulse_width", 64'(fmt_grant_o), 64'd0);
        end
        fmt_start_i = 1'b0;
        fmt_end_i   = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] chid, input int decl, input int act,
                            input logic [31:0] base);
        logic got;
        expect_pkt(chid, decl, act, base);
        fmt_req_i    = 1'b1;
        fmt_length_i = 6'(decl);
        fmt_chid_i   = chid;
        wait_grant(got);
        fmt_req_i = 1'b0;
        send_beats(act, base);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (exp_q.size() == 0 && !pkt_vld_o) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("drain_complete", 64'(done), 64'd1);
        tick();
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pkt_cnt = 0;
        exp_err     = 1'b0;
    endtask

    initial begin
        pkt_rdy_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            pkt_rdy_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (rstn_i && pkt_vld_o && pkt_rdy_i) begin
            pops++;
            mon_got = {pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_chid_o};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got word 0x%0h, required no output", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_word", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int grants;
        int decl;
        logic got;

        tbl[0] = '{chid: 2'd2, decl: 8,  act: 8, exp_words: 8,  exp_err: 1'b0};
        tbl[1] = '{chid: 2'd1, decl: 1,  act: 1, exp_words: 1,  exp_err: 1'b0};
        tbl[2] = '{chid: 2'd3, decl: 63, act: 63, exp_words: 63, exp_err: 1'b0};
        tbl[3] = '{chid: 2'd0, decl: 8,  act: 6, exp_words: 6,  exp_err: 1'b1};
        tbl[4] = '{chid: 2'd1, decl: 4,  act: 7, exp_words: 4,  exp_err: 1'b1};
        tbl[5] = '{chid: 2'd2, decl: 0,  act: 2, exp_words: 0,  exp_err: 1'b1};

        rstn_i = 1'b0;
        fmt_req_i = 1'b0; fmt_chid_i = 2'd0; fmt_length_i = 6'd0;
        fmt_data_i = 32'd0; fmt_start_i = 1'b0; fmt_end_i = 1'b0;
        repeat (3) tick();
        check("rst_vld", 64'(pkt_vld_o), 64'd0);
        check("rst_grant", 64'(fmt_grant_o), 64'd0);
        check("rst_err", 64'(len_err_o), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
        check("rst_head", 64'({pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_chid_o}), 64'd0);
        rstn_i = 1'b1;
        tick();

        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            p0 = pops;
            send_pkt(tbl[r].chid, tbl[r].decl, tbl[r].act, 32'h100 + 32'(r) * 32'h1000);
            drain();
            $display("pkt %0d: decl=%0d act=%0d words=%0d err=%0d cnt=%0d", r, tbl[r].decl,
                     tbl[r].act, pops - p0, len_err_o, pkt_cnt_o);
            check("tbl_words", 64'(pops - p0), 64'(tbl[r].exp_words));
            check("tbl_err", 64'(len_err_o), 64'(tbl[r].exp_err));
            check("tbl_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_pkt_cnt));
        end

        rstn_i = 1'b0;
        tick();
        model_reset();
        rstn_i = 1'b1;
        tick();

        rdy_mode = 2;
        for (int n = 0; n < 20; n++) begin
            decl = int'($urandom_range(1, 40));
            send_pkt(2'($urandom_range(0, 3)), decl, decl, $urandom);
            $display("rand pkt %0d: len=%0d", n, decl);
        end
        drain();
        check("rand_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_pkt_cnt));
        check("rand_err", 64'(len_err_o), 64'(exp_err));

        rdy_mode = 0;
        repeat (2) tick();
        send_pkt(2'd0, 32, 32, 32'hA000);
        send_pkt(2'd1, 32, 32, 32'hB000);
        expect_pkt(2'd2, 32, 32, 32'hC000);
        fmt_req_i = 1'b1; fmt_length_i = 6'd32; fmt_chid_i = 2'd2;
        grants = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fmt_grant_o) grants++;
        end
        check("full_no_grant", 64'(grants), 64'd0);
        p0 = pops;
        rdy_mode = 1;
        wait_grant(got);
        fmt_req_i = 1'b0;
        $display("third grant after %0d pops", pops - p0);
        check("pops_before_grant", 64'(pops - p0), 64'd32);
        send_beats(32, 32'hC000);
        drain();
        check("b2b_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_pkt_cnt));

        expect_pkt(2'd3, 16, 3, 32'hD000);
        fmt_req_i = 1'b1; fmt_length_i = 6'd16; fmt_chid_i = 2'd3;
        wait_grant(got);
        fmt_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fmt_start_i = (i == 0);
            fmt_data_i  = 32'hD000 + 32'(i);
            tick();
        end
        fmt_start_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        model_reset();
        check("midrst_vld", 64'(pkt_vld_o), 64'd0);
        check("midrst_head", 64'({pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_chid_o}), 64'd0);
        check("midrst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
        check("midrst_grant", 64'(fmt_grant_o), 64'd0);
        repeat (2) tick();
        rstn_i = 1'b1;
        tick();
        check("postrst_empty", 64'(pkt_vld_o), 64'd0);
        p0 = pops;
        send_pkt(2'd1, 5, 5, 32'hE000);
        drain();
        check("postrst_words", 64'(pops - p0), 64'd5);
        check("postrst_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
        check("postrst_err", 64'(len_err_o), 64'd0);

`ifdef FMT_SINK_TIMEOUT_EN
        fmt_req_i = 1'b1; fmt_length_i = 6'd4; fmt_chid_i = 2'd0;
        wait_grant(got);
        fmt_req_i = 1'b0;
        repeat (16) tick();
        check("timeout_err", 64'(len_err_o), 64'd1);
        check("timeout_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_pkt_cnt));
        exp_err = 1'b1;
        send_pkt(2'd2, 2, 2, 32'hF000);
        drain();
        check("timeout_next_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_pkt_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
